// File: rtl/pool_2_reader.sv
// pool_2_reader: consumer of the conv2 output buffer (fm_bram_1).
//
// Each pass reads an even/odd word pair through BRAM ports A and B. The bench-free
// summary of the datapath is a 2x2 max pool: an element-wise signed max across the
// two words, then a signed max over adjacent lane pairs. The result is one 25-lane
// vector per pair, presented over a valid/ready handshake. A sticky finish flag is
// raised once every pair has been handed off.
//
// Optional build macro:
//   POOL_2_RELU_EN  - when defined, each pooled lane is clamped to 0 if negative.
//                     Handshake and timing are the same in both builds.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   pool_2_en        level enable; a rising edge (re)starts a pass
//   fm_bram_1_ena    port A read enable (high only in the issue cycle)
//   fm_bram_1_enb    port B read enable (high only in the issue cycle)
//   fm_bram_1_addra  port A address, even word 2p (held outside the issue cycle)
//   fm_bram_1_addrb  port B address, odd word 2p+1 (held outside the issue cycle)
//   fm_bram_1_douta  port A read data, 56 x 16-bit lanes
//   fm_bram_1_doutb  port B read data, 56 x 16-bit lanes
//   out_valid        pooled vector valid
//   out_ready        downstream accept
//   out_data         25 x 16-bit signed pooled lanes, lane j in [j*16 +: 16]
//   out_idx          pair index p of the presented vector
//   pool_2_finish    sticky done flag

module pool_2_reader #(
  parameter int unsigned NUM_WORDS = 32,  // even, <= 128
  parameter int unsigned RD_LAT    = 2,   // 1..3
  parameter int unsigned LANES     = 50   // valid lanes per word; the rest is padding
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pool_2_en,
  output logic         fm_bram_1_ena,
  output logic         fm_bram_1_enb,
  output logic [6:0]   fm_bram_1_addra,
  output logic [6:0]   fm_bram_1_addrb,
  input  logic [895:0] fm_bram_1_douta,
  input  logic [895:0] fm_bram_1_doutb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [399:0] out_data,
  output logic [5:0]   out_idx,
  output logic         pool_2_finish
);

  localparam int unsigned OUT_LANES = LANES / 2;
  localparam int unsigned NUM_PAIRS = NUM_WORDS / 2;
  localparam int unsigned CAP_W     = LANES * 16;
  localparam logic [5:0]  LAST_P    = 6'(NUM_PAIRS - 1);
  localparam logic [1:0]  LAT_INIT  = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StPool,
    StOut,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             r_state;
  logic [5:0]         r_p;
  logic [1:0]         r_cnt;
  logic               r_valid;
  logic               r_finish;
  logic               r_en_d;
  logic [6:0]         r_addra;
  logic [6:0]         r_addrb;
  logic [CAP_W-1:0]   r_cap_a;
  logic [CAP_W-1:0]   r_cap_b;
  logic [399:0]       r_out_data;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_e             w_state_next;
  logic [5:0]         w_p_next;
  logic [1:0]         w_cnt_next;
  logic               w_valid_next;
  logic               w_finish_next;
  logic               w_capture;
  logic               w_load_out;
  logic               w_start;
  logic               w_xfer;
  logic [399:0]       w_pooled;

  // Padding lanes are never looked at; fold them away explicitly.
  logic               w_unused_pad;
  assign w_unused_pad = ^{fm_bram_1_douta[895:CAP_W], fm_bram_1_doutb[895:CAP_W]};

  assign w_start = pool_2_en & ~r_en_d;
  assign w_xfer  = r_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Pooling helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [15:0] lane_out(input logic [15:0] a0, input logic [15:0] a1,
                                           input logic [15:0] b0, input logic [15:0] b1);
    logic [15:0] m;
    m = smax(smax(a0, b0), smax(a1, b1));
`ifdef POOL_2_RELU_EN
    if (m[15]) begin
      m = 16'h0000;
    end
`endif
    return m;
  endfunction

  always_comb begin
    w_pooled = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      w_pooled[16*j +: 16] = lane_out(r_cap_a[32*j +: 16], r_cap_a[32*j+16 +: 16],
                                      r_cap_b[32*j +: 16], r_cap_b[32*j+16 +: 16]);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_p_next      = r_p;
    w_cnt_next    = r_cnt;
    w_valid_next  = r_valid;
    w_finish_next = r_finish;
    w_capture     = 1'b0;
    w_load_out    = 1'b0;

    if (w_start) begin
      // A fresh rising edge wins over whatever the pass was doing.
      w_state_next  = StIssue;
      w_p_next      = 6'd0;
      w_valid_next  = 1'b0;
      w_finish_next = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_next = StIdle;
        end
        StIssue: begin
          w_state_next = StWait;
          w_cnt_next   = LAT_INIT;
        end
        StWait: begin
          // Counter reaches 0 in the cycle RD_LAT after issue, when dout is valid.
          if (r_cnt == 2'd0) begin
            w_capture    = 1'b1;
            w_state_next = StPool;
          end else begin
            w_cnt_next = r_cnt - 2'd1;
          end
        end
        StPool: begin
          w_load_out   = 1'b1;
          w_valid_next = 1'b1;
          w_state_next = StOut;
        end
        StOut: begin
          if (w_xfer) begin
            w_valid_next = 1'b0;
            if (r_p == LAST_P) begin
              w_finish_next = 1'b1;
              w_state_next  = StDone;
            end else begin
              w_p_next     = r_p + 6'd1;
              w_state_next = StIssue;
            end
          end
        end
        StDone: begin
          w_state_next = StDone;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_p        <= 6'd0;
      r_cnt      <= 2'd0;
      r_valid    <= 1'b0;
      r_finish   <= 1'b0;
      r_en_d     <= 1'b0;
      r_addra    <= 7'd0;
      r_addrb    <= 7'd0;
      r_cap_a    <= '0;
      r_cap_b    <= '0;
      r_out_data <= '0;
    end else begin
      r_state  <= w_state_next;
      r_p      <= w_p_next;
      r_cnt    <= w_cnt_next;
      r_valid  <= w_valid_next;
      r_finish <= w_finish_next;
      r_en_d   <= pool_2_en;
      // Addresses are set up on entry to ISSUE and then simply held.
      if (w_state_next == StIssue) begin
        r_addra <= {w_p_next, 1'b0};
        r_addrb <= {w_p_next, 1'b1};
      end
      if (w_capture) begin
        r_cap_a <= fm_bram_1_douta[CAP_W-1:0];
        r_cap_b <= fm_bram_1_doutb[CAP_W-1:0];
      end
      if (w_load_out) begin
        r_out_data <= w_pooled;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fm_bram_1_ena   = (r_state == StIssue);
  assign fm_bram_1_enb   = (r_state == StIssue);
  assign fm_bram_1_addra = r_addra;
  assign fm_bram_1_addrb = r_addrb;
  assign out_valid       = r_valid;
  assign out_data        = r_out_data;
  assign out_idx         = r_p;
  assign pool_2_finish   = r_finish;

endmodule

// File: tb/tb_pool_2_reader.sv
module tb_pool_2_reader;

  localparam int unsigned NW = 4;
  localparam int unsigned RL = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         pool_2_en;
  logic         ena, enb;
  logic [6:0]   addra, addrb;
  logic [895:0] douta, doutb;
  logic         out_valid;
  logic         out_ready;
  logic [399:0] out_data;
  logic [5:0]   out_idx;
  logic         finish;

  always #5 clk = ~clk;

  pool_2_reader #(
    .NUM_WORDS(NW),
    .RD_LAT   (RL),
    .LANES    (50)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pool_2_en      (pool_2_en),
    .fm_bram_1_ena  (ena),
    .fm_bram_1_enb  (enb),
    .fm_bram_1_addra(addra),
    .fm_bram_1_addrb(addrb),
    .fm_bram_1_douta(douta),
    .fm_bram_1_doutb(doutb),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .pool_2_finish  (finish)
  );

  // BRAM model: RL-cycle read latency, output register updates only on enable.
  logic [895:0] mem [128];
  logic [895:0] pa  [RL];
  logic [895:0] pb  [RL];

  always @(posedge clk) begin
    if (ena) pa[0] <= mem[addra];
    if (enb) pb[0] <= mem[addrb];
    for (int k = 1; k < RL; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign douta = pa[RL-1];
  assign doutb = pb[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [399:0] d;
    logic [5:0]   idx;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_xfer = 0;
  int   xfer_cyc[$];
  int   fin_cyc = -1;
  logic fin_prev = 1'b0;

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_push(input logic [399:0] d, input logic [5:0] idx);
    exp_t e;
    e.d   = d;
    e.idx = idx;
    sb_q.push_back(e);
  endtask

  // Reference: signed max over the four contributing values of each output lane.
  function automatic logic [399:0] model_vec(input logic [895:0] a, input logic [895:0] b);
    logic [399:0] v;
    logic [15:0]  c [4];
    logic [15:0]  m;
    v = '0;
    for (int j = 0; j < 25; j++) begin
      c[0] = a[32*j +: 16];
      c[1] = a[32*j+16 +: 16];
      c[2] = b[32*j +: 16];
      c[3] = b[32*j+16 +: 16];
      m = c[0];
      for (int k = 1; k < 4; k++) begin
        if ($signed(c[k]) > $signed(m)) m = c[k];
      end
`ifdef POOL_2_RELU_EN
      if ($signed(m) < 0) m = 16'h0000;
`endif
      v[16*j +: 16] = m;
    end
    return v;
  endfunction

  task automatic push_model_pass();
    for (int p = 0; p < NW / 2; p++) begin
      sb_push(model_vec(mem[2*p], mem[2*p+1]), 6'(p));
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 56; i++) begin
      mem[0][16*i +: 16] = 16'(i);
      mem[1][16*i +: 16] = 16'(100 + i);
      mem[2][16*i +: 16] = 16'hFFFF;
      mem[3][16*i +: 16] = 16'hFFFE;
    end
  endtask

  task automatic push_basic();
    logic [399:0] v0, v1;
    for (int j = 0; j < 25; j++) begin
      v0[16*j +: 16] = 16'(101 + 2 * j);
`ifdef POOL_2_RELU_EN
      v1[16*j +: 16] = 16'h0000;
`else
      v1[16*j +: 16] = 16'hFFFF;
`endif
    end
    sb_push(v0, 6'd0);
    sb_push(v1, 6'd1);
  endtask

  // Drives a falling then rising edge of pool_2_en; returns early in the ISSUE cycle.
  task automatic start_pass();
    pool_2_en = 1'b0;
    @(posedge clk); #1;
    pool_2_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_finish(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!finish && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!finish) chk(tag, 400'(finish), 400'(1));
  endtask

  // Scoreboard consumer: every accepted vector is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          n_xfer++;
          xfer_cyc.push_back(cyc);
          if (sb_q.size() == 0) begin
            chk("sb_extra_vector", 400'(out_idx), '1);
          end else begin
            e = sb_q.pop_front();
            chk("vec_data", out_data, e.d);
            chk("vec_idx", 400'(out_idx), 400'(e.idx));
          end
        end
        if (finish && !fin_prev) fin_cyc = cyc;
        fin_prev = finish;
      end
    end
  end

  initial begin
    int seen, base, gap, n;
    logic [399:0] v0;
    rst       = 1'b1;
    pool_2_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;

    // Reset / idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ena",    400'(ena),       400'(0));
    chk("rst_enb",    400'(enb),       400'(0));
    chk("rst_addra",  400'(addra),     400'(0));
    chk("rst_addrb",  400'(addrb),     400'(0));
    chk("rst_valid",  400'(out_valid), 400'(0));
    chk("rst_data",   out_data,        400'(0));
    chk("rst_idx",    400'(out_idx),   400'(0));
    chk("rst_finish", 400'(finish),    400'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ena || enb || out_valid || finish) seen++;
    end
    chk("idle_quiet", 400'(seen), 400'(0));

    // Basic pass, ready held high
    load_basic();
    push_basic();
    out_ready = 1'b1;
    base = n_xfer;
    xfer_cyc.delete();
    fin_cyc = -1;
    start_pass();
    wait_finish("basic_timeout", 200);
    chk("basic_nxfer", 400'(n_xfer - base), 400'(2));
    gap = (xfer_cyc.size() >= 2) ? xfer_cyc[1] - xfer_cyc[0] : -1;
    chk("basic_period", 400'(gap), 400'(RL + 3));
    gap = (xfer_cyc.size() >= 2) ? fin_cyc - xfer_cyc[1] : -1;
    chk("basic_fin_lat", 400'(gap), 400'(1));
    chk("basic_sb_empty", 400'(sb_q.size()), 400'(0));

    // Level-high enable in DONE does not restart
    repeat (10) @(negedge clk);
    chk("done_no_restart_en", 400'(ena), 400'(0));
    chk("done_finish_held",   400'(finish), 400'(1));

    // Backpressure on vector 0
    push_basic();
    out_ready = 1'b0;
    start_pass();
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", 400'(out_valid), 400'(1));
    for (int i = 0; i < 7; i++) begin
      v0 = (sb_q.size() > 0) ? sb_q[0].d : '1;
      chk("bp_valid", 400'(out_valid), 400'(1));
      chk("bp_data",  out_data, v0);
      chk("bp_idx",   400'(out_idx), 400'(0));
      chk("bp_no_en", 400'(ena | enb), 400'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_finish("bp_timeout", 200);
    chk("bp_sb_empty", 400'(sb_q.size()), 400'(0));

    // Signed compare (pair 0) and padding lanes (pair 1)
    for (int j = 0; j < 25; j++) begin
      mem[0][32*j +: 32] = {16'h7FFF, 16'h8000};
      mem[1][32*j +: 32] = {16'h0001, 16'hFFFF};
      mem[2][32*j +: 32] = 32'h0;
      mem[3][32*j +: 32] = 32'h0;
      v0[16*j +: 16]     = 16'h7FFF;
    end
    for (int w = 0; w < 4; w++) begin
      for (int i = 50; i < 56; i++) mem[w][16*i +: 16] = 16'h7FFF;
    end
    sb_push(v0, 6'd0);
    sb_push(400'(0), 6'd1);
    start_pass();
    wait_finish("sp_timeout", 200);
    chk("sp_sb_empty", 400'(sb_q.size()), 400'(0));

    // Random data with random backpressure
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 28; k++) mem[w][32*k +: 32] = $urandom;
    end
    push_model_pass();
    start_pass();
    n = 0;
    while (!finish && n < 400) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("rnd_timeout", 400'(finish), 400'(1));
    chk("rnd_sb_empty", 400'(sb_q.size()), 400'(0));

    // Restart while vector 1 is held in OUT
    out_ready = 1'b1;
    push_model_pass();
    base = n_xfer;
    start_pass();
    n = 0;
    while (n_xfer == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rs_first_xfer", 400'(n_xfer - base), 400'(1));
    @(posedge clk); #1;
    out_ready = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 6'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rs_held_idx", 400'(out_idx), 400'(1));
    sb_q.delete();
    push_model_pass();
    xfer_cyc.delete();
    fin_cyc = -1;
    start_pass();
    @(negedge clk);
    chk("rs_valid_drop", 400'(out_valid), 400'(0));
    chk("rs_ena",        400'(ena),       400'(1));
    chk("rs_enb",        400'(enb),       400'(1));
    chk("rs_addra",      400'(addra),     400'(0));
    chk("rs_addrb",      400'(addrb),     400'(1));
    chk("rs_finish",     400'(finish),    400'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = n_xfer;
    wait_finish("rs_timeout", 200);
    chk("rs_nxfer", 400'(n_xfer - base), 400'(2));
    gap = (xfer_cyc.size() >= 2) ? fin_cyc - xfer_cyc[1] : -1;
    chk("rs_fin_lat", 400'(gap), 400'(1));
    chk("rs_sb_empty", 400'(sb_q.size()), 400'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_2_reader.md
Name: pool_2_reader

Overview:
- Consumer of the conv2 output buffer (fm_bram_1).
- Reads the packed 16-bit conv2 results through both BRAM ports, one even/odd word pair per pass.
- Applies 2x2 max pooling: an element-wise max across the two words, then a max over adjacent lane pairs.
- Presents one 25-lane pooled vector per pair to the next layer over a valid/ready handshake, then flags completion.

Parameters:
- NUM_WORDS, 32, number of fm_bram_1 words to consume; must be even and ≤ 128.
- RD_LAT, 2, fm_bram_1 read latency in cycles from en/addr to dout; legal range 1–3.
- LANES, 50, valid 16-bit lanes per word (lanes 50–55 are padding and are ignored).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- pool_2_en  input  1  level enable; its rising edge starts a pass.
- fm_bram_1_ena  output  1  port A read enable.
- fm_bram_1_enb  output  1  port B read enable.
- fm_bram_1_addra  output  7  port A address (even word).
- fm_bram_1_addrb  output  7  port B address (odd word).
- fm_bram_1_douta  input  896  port A read data, 56x16.
- fm_bram_1_doutb  input  896  port B read data, 56x16.
- out_valid  output  1  pooled vector valid.
- out_ready  input  1  downstream accept.
- out_data  output  400  25x16 signed pooled lanes; lane j in [j*16 +: 16].
- out_idx  output  6  pair index p of the current vector.
- pool_2_finish  output  1  sticky done flag.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; p=0.
- Start: start pulse = pool_2_en & ~pool_2_en_d. A start in any state, including mid-pass, aborts the current pass and moves to ISSUE with p=0, out_valid=0, pool_2_finish=0.
- IDLE: remain here until a start pulse.
- ISSUE (1 cycle):
  - ena=enb=1, addra=2p, addrb=2p+1.
  - Go to WAIT with the latency counter loaded to RD_LAT-1.
  - ena/enb are 0 in every other state.
  - Addresses hold their last value outside ISSUE.
- WAIT:
  - Decrement the counter; at 0, capture douta/doutb into a result register.
  - The capture occurs exactly RD_LAT cycles after the ISSUE cycle.
- Pooling, on the captured data, for j=0..24:
  - m0 = smax(A[2j], B[2j]); m1 = smax(A[2j+1], B[2j+1]); out lane j = smax(m0, m1).
  - All compares are 16-bit two's-complement signed.
  - Result is registered; out_valid rises the cycle after capture; go to OUT.
- OUT:
  - out_data and out_idx are held stable while out_valid=1 and out_ready=0.
  - A transfer happens on a cycle with out_valid & out_ready.
  - After a transfer with p < NUM_WORDS/2-1: out_valid drops, p increments, go to ISSUE the next cycle.
  - After a transfer with p = NUM_WORDS/2-1: out_valid drops, pool_2_finish=1 the next cycle, go to DONE.
- Throughput: at most one vector per RD_LAT+3 cycles. out_ready held high gives exactly RD_LAT+3 cycles per vector.
- DONE: pool_2_finish remains 1 until rst or a new start pulse. A level-high pool_2_en does not restart the pass.
- pool_2_en falling mid-pass: no effect; the pass completes.
- out_ready high while out_valid=0: ignored.
- Padding lanes 50–55 never affect the output.

Optional Feature:
- Macro: POOL_2_RELU_EN.
- Defined: each output lane is clamped to 0 when negative (MSB=1), after the max; values ≥0 pass unchanged.
- Undefined: raw signed max is output; negative values pass through.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset/idle: hold rst 3 cycles with pool_2_en=0 → all outputs 0; no enables for 20 cycles.
- Basic pass, RD_LAT=2, NUM_WORDS=4, out_ready=1:
  - Stimulus: word0 lanes = i, word1 lanes = 100+i, word2 = -1, word3 = -2.
  - Required: vector 0 lane j = 101+2j, out_idx=0; vector 1 lanes = -1.
  - Required: vectors are 5 cycles apart; pool_2_finish rises 1 cycle after the second transfer.
- Backpressure: out_ready=0 for 7 cycles on vector 0 → out_valid, out_data and out_idx are stable; no BRAM enable fires until the transfer.
- Signed compare: A lane pair = 0x8000/0x7FFF, B lane pair = 0xFFFF/0x0001 → lane = 0x7FFF.
- Padding: put 0x7FFF in lanes 50–55 of all words with valid lanes = 0 → all outputs 0.
- Restart mid-pass: pulse pool_2_en low then high while in OUT with p=1 → out_valid drops; next addresses are addra=0/addrb=1; finish stays 0 until the new pass ends.
- With POOL_2_RELU_EN defined: rerun the basic pass → vector 1 lanes = 0.
